// File: rtl/sync_tx_arbiter_pkg.sv
// Shared definitions for the sync_tx_arbiter slice: FSM state encoding,
// default word width and watchdog limit, and the watchdog width helper.
package sync_tx_arbiter_pkg;

  localparam int DATA_WIDTHS     = 8;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  // Watchdog counter width: wide enough for the limit, kept within 8..16 bits.
  function automatic int wdog_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/sync_tx_arbiter_rr_pick.sv
// Combinational round-robin select: the search starts at ptr and wraps,
// returning the winner both one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the closest requester wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    cand   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (req[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sync_tx_arbiter.sv
// Round-robin arbiter sharing the transmit side of sync_multi between
// NUM_REQ requesters. Optional watchdog enabled by SYNC_ARB_TIMEOUT_EN.
module sync_tx_arbiter
  import sync_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTHS,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_v,
  input  logic                          tx_f,
  output logic                          busy,
  output logic                          err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t              state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_v_q, tx_v_d;
  logic                    busy_q, busy_d;

  logic [NUM_REQ-1:0]      pick_winner;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_any;
  logic [PTR_W-1:0]        next_ptr;
  logic [DATA_WIDTH-1:0]   pick_word;
  logic                    wdog_fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  // Extract the winning requester's word using constant slice bases.
  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == PTR_W'(i)) pick_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef SYNC_ARB_TIMEOUT_EN
  localparam int CNT_W = wdog_width(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             stalled;

  assign stalled   = ((state_q == ST_WAIT_BUSY) && !tx_f) || ((state_q == ST_WAIT_DONE) && tx_f);
  assign wdog_fire = stalled && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog counts every cycle spent in either wait state; err is sticky.
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) cnt_d = cnt_q + CNT_W'(1);
    if (wdog_fire) err_d = 1'b1;
  end

  // Watchdog counter and error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  // TIMEOUT stays referenced so the parameter list is identical in both builds.
  assign unused_timeout = ^TIMEOUT;
  assign wdog_fire      = 1'b0;
  assign err            = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    tx_data_d = tx_data_q;
    grant_d   = '0;
    done_d    = '0;
    tx_v_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !tx_f) begin
          state_d   = ST_SEND;
          owner_d   = pick_idx;
          grant_d   = pick_winner;
          tx_data_d = pick_word;
          tx_v_d    = 1'b1;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_f) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_f) begin
          state_d = ST_IDLE;
          done_d  = NUM_REQ'(1) << owner_q;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (wdog_fire) begin
      state_d = ST_IDLE;
      ptr_d   = next_ptr;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer, latched word and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      tx_data_q <= '0;
      tx_v_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      tx_data_q <= tx_data_d;
      tx_v_q    <= tx_v_d;
      busy_q    <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign tx_data = tx_data_q;
  assign tx_v    = tx_v_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Directed bench for sync_tx_arbiter; the synchronizer's f flag is driven
// by hand so every handshake phase lands on a known cycle.
module tb_sync_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  tx_data;
  logic        tx_v;
  logic        tx_f;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  sync_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .TIMEOUT    (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .tx_data  (tx_data),
    .tx_v     (tx_v),
    .tx_f     (tx_f),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // One clock, then settle past the edge before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    req      = '0;
    tx_f     = 1'b0;
    req_data = '0;
    step();
    reset = 1'b0;
  endtask

  // Plays the synchronizer: f rises after 'lead' cycles, stays for 'hold', then falls.
  task automatic run_sync(input int lead, input int hold);
    repeat (lead) step();
    tx_f = 1'b1;
    repeat (hold) step();
    tx_f = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    tx_f  = 1'b0;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (done !== 4'b0000) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0000", done); end
    checks++; if (tx_v !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_v: got %b expected 0", tx_v); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    req   = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    req_data[7:0] = 8'hA5;
    req           = 4'b0001;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant: got %b expected 0001", grant); end
    checks++; if (tx_v !== 1'b1) begin errors++; $display("[TB] FAIL single_tx_v_high: got %b expected 1", tx_v); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_tx_data: got %h expected a5", tx_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_send: got %b expected 1", busy); end
    req           = '0;
    req_data[7:0] = 8'h5A;
    step();
    checks++; if (tx_v !== 1'b0) begin errors++; $display("[TB] FAIL single_tx_v_low: got %b expected 0", tx_v); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL single_grant_pulse: got %b expected 0000", grant); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_data_hold: got %h expected a5", tx_data); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_wait: got %b expected 1", busy); end
    tx_f = 1'b1;
    step();
    step();
    checks++; if (done !== 4'b0000) begin errors++; $display("[TB] FAIL single_done_early: got %b expected 0000", done); end
    tx_f = 1'b0;
    step();
    checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL single_done: got %b expected 0001", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_idle: got %b expected 0", busy); end
    step();
    checks++; if (done !== 4'b0000) begin errors++; $display("[TB] FAIL single_done_pulse: got %b expected 0000", done); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_data_after: got %h expected a5", tx_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    apply_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req      = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1 << (k % 4));
      exp_d = 8'(8'h10 + (k % 4));
      checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, grant, exp_g); end
      checks++; if (tx_data !== exp_d) begin errors++; $display("[TB] FAIL rr_data_%0d: got %h expected %h", k, tx_data, exp_d); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rr_busy_%0d: got %b expected 1", k, busy); end
      run_sync(1, 2);
      checks++; if (done !== exp_g) begin errors++; $display("[TB] FAIL rr_done_%0d: got %b expected %b", k, done, exp_g); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL rr_overlap_%0d: got %b expected 0000", k, grant); end
      step();
    end
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL rr_grant_5: got %b expected 0010", grant); end
    req = '0;
    run_sync(1, 1);
    checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL rr_done_5: got %b expected 0010", done); end
  endtask

  task automatic test_wrap();
    apply_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req      = 4'b1000;
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_grant3: got %b expected 1000", grant); end
    checks++; if (tx_data !== 8'h13) begin errors++; $display("[TB] FAIL wrap_data3: got %h expected 13", tx_data); end
    req = '0;
    run_sync(1, 1);
    checks++; if (done !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_done3: got %b expected 1000", done); end
    req = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL wrap_grant2: got %b expected 0100", grant); end
    checks++; if (tx_data !== 8'h12) begin errors++; $display("[TB] FAIL wrap_data2: got %h expected 12", tx_data); end
    req = '0;
    run_sync(2, 1);
    checks++; if (done !== 4'b0100) begin errors++; $display("[TB] FAIL wrap_done2: got %b expected 0100", done); end
    req = 4'b0011;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_from3: got %b expected 0001", grant); end
    req = 4'b0010;
    run_sync(1, 1);
    checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_done0: got %b expected 0001", done); end
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_grant1: got %b expected 0010", grant); end
    req = '0;
    run_sync(1, 1);
  endtask

  task automatic test_f_block();
    apply_reset();
    tx_f            = 1'b1;
    req_data[31:24] = 8'hC3;
    req             = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL fblock_grant_%0d: got %b expected 0000", i, grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fblock_busy_%0d: got %b expected 0", i, busy); end
    end
    tx_f = 1'b0;
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL fblock_release: got %b expected 1000", grant); end
    checks++; if (tx_data !== 8'hC3) begin errors++; $display("[TB] FAIL fblock_data: got %h expected c3", tx_data); end
    req = '0;
    run_sync(1, 1);
    checks++; if (done !== 4'b1000) begin errors++; $display("[TB] FAIL fblock_done: got %b expected 1000", done); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] done_acc;
    apply_reset();
    req_data[7:0] = 8'h77;
    req           = 4'b0001;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_grant: got %b expected 0001", grant); end
    req = '0;
    step();
    tx_f = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rmid_busy_before: got %b expected 1", busy); end
    #1;
    reset = 1'b1;
    tx_f  = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy_async: got %b expected 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL rmid_data_async: got %h expected 00", tx_data); end
    checks++; if ({tx_v, grant, done} !== 9'b0) begin errors++; $display("[TB] FAIL rmid_pulses_async: got %b expected 000000000", {tx_v, grant, done}); end
    step();
    reset           = 1'b0;
    req_data[15:8]  = 8'h3C;
    req             = 4'b0010;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL rmid_regrant: got %b expected 0010", grant); end
    checks++; if (tx_data !== 8'h3C) begin errors++; $display("[TB] FAIL rmid_redata: got %h expected 3c", tx_data); end
    req      = '0;
    done_acc = '0;
    repeat (2) begin
      step();
      done_acc |= done;
    end
    tx_f = 1'b1;
    step();
    done_acc |= done;
    tx_f = 1'b0;
    step();
    checks++; if (done_acc !== 4'b0000) begin errors++; $display("[TB] FAIL rmid_stale_done: got %b expected 0000", done_acc); end
    checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL rmid_done: got %b expected 0010", done); end
  endtask

  task automatic test_stuck();
    logic [3:0] done_acc;
    apply_reset();
    req_data[7:0] = 8'hE1;
    req           = 4'b0001;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL stuck_grant: got %b expected 0001", grant); end
    req      = '0;
    tx_f     = 1'b1;
    done_acc = '0;
    repeat (17) begin
      step();
      done_acc |= done;
    end
    checks++; if (done_acc !== 4'b0000) begin errors++; $display("[TB] FAIL stuck_no_done: got %b expected 0000", done_acc); end
`ifdef SYNC_ARB_TIMEOUT_EN
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL stuck_err: got %b expected 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stuck_idle: got %b expected 0", busy); end
    tx_f = 1'b0;
    req  = 4'b0011;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL stuck_ptr_skip: got %b expected 0010", grant); end
    req = '0;
    run_sync(1, 1);
    checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL stuck_after_done: got %b expected 0010", done); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL stuck_err_sticky: got %b expected 1", err); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL stuck_err: got %b expected 0", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stuck_waiting: got %b expected 1", busy); end
    repeat (20) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stuck_still_waiting: got %b expected 1", busy); end
    tx_f = 1'b0;
    step();
    checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL stuck_late_done: got %b expected 0001", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL stuck_err_end: got %b expected 0", err); end
`endif
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    tx_f     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_f_block();
    test_reset_mid();
    test_stuck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
